// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencer: state encoding and default datapath geometry.
package fir_pkg;

  localparam int unsigned FIR_L   = 15;
  localparam int unsigned FIR_W1  = 9;
  localparam int unsigned FIR_W4  = 11;
  localparam int unsigned FIR_LAT = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StFlush = 2'd2,
    StRun   = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_tag_pipe.sv
// Valid-tag delay line matching the datapath latency; clr_i empties every stage on the next edge.
module fir_tag_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic tag_i,
  output logic tag_o
);

  logic [Depth-1:0] pipe_d, pipe_q;

  always_comb begin
    pipe_d = '0;
    if (!clr_i) begin
      pipe_d[0] = tag_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// Coefficient-load / sample-run sequencer for the transposed FIR datapath.
// Define FIR_SEQ_FLUSH_EN to flush L zeros after each load instead of gating warm-up outputs.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned W1  = FIR_W1,
  parameter int unsigned W4  = FIR_W4,
  parameter int unsigned L   = FIR_L,
  parameter int unsigned LAT = FIR_LAT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_start_i,
  input  logic          c_valid_i,
  input  logic [W1-1:0] c_data_i,
  output logic          c_ready_o,
  input  logic          s_valid_i,
  input  logic [W1-1:0] s_data_i,
  output logic          s_ready_o,
  output logic          fir_load_x_o,
  output logic [W1-1:0] fir_x_in_o,
  output logic [W1-1:0] fir_c_in_o,
  input  logic [W4-1:0] fir_y_i,
  output logic          m_valid_o,
  output logic [W4-1:0] m_data_o,
  output logic          busy_o,
  output logic          underrun_o
);

  localparam int unsigned CntW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(L - 1);

`ifdef FIR_SEQ_FLUSH_EN
  localparam fir_state_e AfterLoad = StFlush;
`else
  localparam fir_state_e AfterLoad = StRun;
`endif

  fir_state_e state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic underrun_d, underrun_q;
  logic cnt_last;
  logic cfg_go;
  logic warm_done;
  logic tag_in;

  assign cnt_last = (cnt_q == LastCnt);
  // cfg_start is ignored while a load is already in progress.
  assign cfg_go   = cfg_start_i && (state_q != StLoad);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_start_i) state_d = StLoad;
      StLoad:  if (c_valid_i && cnt_last) state_d = AfterLoad;
      StFlush: begin
        if (cfg_start_i) begin
          state_d = StLoad;
        end else if (cnt_last) begin
          state_d = StRun;
        end
      end
      StRun:   if (cfg_start_i) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; ready signals depend on state only.
  always_comb begin
    fir_load_x_o = 1'b1;
    fir_x_in_o   = '0;
    fir_c_in_o   = '0;
    c_ready_o    = 1'b0;
    s_ready_o    = 1'b0;
    unique case (state_q)
      StLoad: begin
        c_ready_o    = 1'b1;
        fir_c_in_o   = c_data_i;
        fir_load_x_o = !c_valid_i;
      end
      StRun: begin
        s_ready_o  = 1'b1;
        fir_x_in_o = s_valid_i ? s_data_i : '0;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != StRun);

  // Shared beat / flush counter.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_go) begin
      cnt_d = '0;
    end else if ((state_q == StLoad && c_valid_i) || state_q == StFlush) begin
      cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef FIR_SEQ_FLUSH_EN
  assign warm_done = 1'b1;
`else
  // Without a flush the first L-1 outputs mix in stale history, so their tags are dropped.
  logic [CntW-1:0] warm_d, warm_q;

  assign warm_done = (warm_q == LastCnt);

  always_comb begin
    warm_d = warm_q;
    if (state_q != StRun || cfg_start_i) begin
      warm_d = '0;
    end else if (!warm_done) begin
      warm_d = warm_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      warm_q <= '0;
    end else begin
      warm_q <= warm_d;
    end
  end
`endif

  always_comb begin
    underrun_d = underrun_q;
    if (cfg_start_i) begin
      underrun_d = 1'b0;
    end else if (state_q == StRun && !s_valid_i && warm_done) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_o = underrun_q;

  assign tag_in = (state_q == StRun) && s_valid_i && warm_done;

  // Clearing on cfg_start also drops the tag of a sample accepted in that same cycle.
  fir_tag_pipe #(
    .Depth (LAT)
  ) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cfg_go),
    .tag_i  (tag_in),
    .tag_o  (m_valid_o)
  );

  assign m_data_o = fir_y_i;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl with a behavioural transposed-FIR datapath stand-in.
module tb_fir_seq_ctrl;
  import fir_pkg::*;

  localparam int unsigned W1  = FIR_W1;
  localparam int unsigned W4  = FIR_W4;
  localparam int unsigned L   = FIR_L;
  localparam int unsigned LAT = FIR_LAT;
`ifdef FIR_SEQ_FLUSH_EN
  localparam bit FlushEn = 1'b1;
  localparam int WarmN   = 0;
`else
  localparam bit FlushEn = 1'b0;
  localparam int WarmN   = L - 1;
`endif

  logic          clk_i, rst_ni, cfg_start_i;
  logic          c_valid_i, c_ready_o, s_valid_i, s_ready_o;
  logic [W1-1:0] c_data_i, s_data_i, fir_x_in_o, fir_c_in_o;
  logic          fir_load_x_o, m_valid_o, busy_o, underrun_o;
  logic [W4-1:0] fir_y_i, m_data_o;

  fir_seq_ctrl #(
    .W1  (W1),
    .W4  (W4),
    .L   (L),
    .LAT (LAT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_start_i  (cfg_start_i),
    .c_valid_i    (c_valid_i),
    .c_data_i     (c_data_i),
    .c_ready_o    (c_ready_o),
    .s_valid_i    (s_valid_i),
    .s_data_i     (s_data_i),
    .s_ready_o    (s_ready_o),
    .fir_load_x_o (fir_load_x_o),
    .fir_x_in_o   (fir_x_in_o),
    .fir_c_in_o   (fir_c_in_o),
    .fir_y_i      (fir_y_i),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .busy_o       (busy_o),
    .underrun_o   (underrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Datapath stand-in: coefficient k multiplies the sample from k clocks ago.
  logic signed [W1-1:0] mc [L];
  logic signed [W1-1:0] mx [L];
  logic [W4-1:0] my1, my2;

  function automatic int model_sum();
    int acc = int'(mc[0]) * int'($signed(fir_x_in_o));
    for (int k = 1; k < L; k++) acc += int'(mc[k]) * int'(mx[k-1]);
    return acc;
  endfunction

  always @(posedge clk_i) begin
    if (!fir_load_x_o) begin
      for (int k = L - 1; k > 0; k--) mc[k] <= mc[k-1];
      mc[0] <= fir_c_in_o;
    end else begin
      for (int k = L - 1; k > 0; k--) mx[k] <= mx[k-1];
      mx[0] <= fir_x_in_o;
    end
    my1 <= W4'(model_sum());
    my2 <= my1;
  end
  assign fir_y_i = my2;

  int cyc    = 0;
  int lowcnt = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) if (rst_ni && !fir_load_x_o) lowcnt <= lowcnt + 1;

  typedef struct {
    int            due;
    logic [W4-1:0] y;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("m_valid", m_valid_o, 1);
        chk("m_data", m_data_o, sb[0].y);
        void'(sb.pop_front());
      end else if (m_valid_o) begin
        chk("m_valid_spurious", m_valid_o, 0);
      end
    end
  end

  int  coef [L];
  int  sh   [L];
  int  run_cnt;
  logic exp_ur;

  task automatic chk_reset(input string tag);
    chk({tag, "_load_x"}, fir_load_x_o, 1);
    chk({tag, "_x_in"}, fir_x_in_o, 0);
    chk({tag, "_c_in"}, fir_c_in_o, 0);
    chk({tag, "_ready"}, {c_ready_o, s_ready_o}, 2'b00);
    chk({tag, "_m_valid"}, m_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 1);
    chk({tag, "_underrun"}, underrun_o, 0);
  endtask

  task automatic start_load();
    cfg_start_i = 1'b1;
    @(negedge clk_i);
    chk("idle_c_ready", c_ready_o, 0);
    @(posedge clk_i); #1;
    cfg_start_i = 1'b0;
  endtask

  task automatic load_coeffs(input int base, input int step, input bit gaps);
    for (int j = 0; j < int'(L); j++) begin
      if (gaps && (j == 5 || j == 10)) begin
        for (int g = 0; g < 3; g++) begin
          c_valid_i   = 1'b0;
          c_data_i    = 9'h1AA;
          cfg_start_i = (g == 1);
          @(negedge clk_i);
          chk("gap_load_x", fir_load_x_o, 1);
          chk("gap_x_in", fir_x_in_o, 0);
          chk("gap_c_ready", c_ready_o, 1);
          @(posedge clk_i); #1;
          cfg_start_i = 1'b0;
        end
      end
      c_valid_i = 1'b1;
      c_data_i  = W1'(base + step * j);
      @(negedge clk_i);
      chk("beat_load_x", fir_load_x_o, 0);
      chk("beat_c_in", fir_c_in_o, c_data_i);
      chk("beat_ready", {c_ready_o, s_ready_o}, 2'b10);
      chk("beat_busy", busy_o, 1);
      chk("beat_underrun", underrun_o, exp_ur);
      coef[L-1-j] = base + step * j;
      @(posedge clk_i); #1;
    end
    c_valid_i = 1'b0;
  endtask

  task automatic flush_phase();
`ifdef FIR_SEQ_FLUSH_EN
    for (int i = 0; i < int'(L); i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 9'h0AB;
      @(negedge clk_i);
      chk("flush_busy", busy_o, 1);
      chk("flush_s_ready", s_ready_o, 0);
      chk("flush_x_in", fir_x_in_o, 0);
      chk("flush_load_x", fir_load_x_o, 1);
      @(posedge clk_i); #1;
    end
    s_valid_i = 1'b0;
`endif
  endtask

  task automatic enter_run();
    for (int k = 0; k < int'(L); k++) sh[k] = 0;
    run_cnt = 0;
  endtask

  task automatic run_cycle(input logic v, input logic [W1-1:0] d, input logic start);
    int  acc;
    bit  warm;
    sb_t e;
    s_valid_i   = v;
    s_data_i    = d;
    cfg_start_i = start;
    @(negedge clk_i);
    chk("run_busy", busy_o, 0);
    chk("run_ready", {c_ready_o, s_ready_o}, 2'b01);
    chk("run_load_x", fir_load_x_o, 1);
    chk("run_x_in", fir_x_in_o, v ? d : '0);
    chk("underrun", underrun_o, exp_ur);
    for (int k = L - 1; k > 0; k--) sh[k] = sh[k-1];
    sh[0] = v ? int'($signed(d)) : 0;
    if (start) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      exp_ur = 1'b0;
    end else begin
      warm = FlushEn || (run_cnt >= int'(L) - 1);
      if (v && warm) begin
        acc = 0;
        for (int k = 0; k < int'(L); k++) acc += coef[k] * sh[k];
        e.due = cyc + int'(LAT);
        e.y   = W4'(acc);
        sb.push_back(e);
      end
      if (!v && warm) exp_ur = 1'b1;
      run_cnt++;
    end
    @(posedge clk_i); #1;
    s_valid_i   = 1'b0;
    cfg_start_i = 1'b0;
  endtask

  int l0;

  initial begin
    rst_ni = 1'b1; cfg_start_i = 1'b0; c_valid_i = 1'b0; c_data_i = '0;
    s_valid_i = 1'b0; s_data_i = '0; exp_ur = 1'b0; run_cnt = 0;
    #3 rst_ni = 1'b0;
    #1 chk_reset("por");
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk("idle", {busy_o, m_valid_o, c_ready_o, s_ready_o}, 4'b1000);
      @(posedge clk_i); #1;
    end

    // Load 1..15 with two 3-cycle gaps (one carrying an ignored cfg_start).
    start_load();
    l0 = lowcnt;
    load_coeffs(1, 1, 1'b1);
    chk("load_x_low_cycles", lowcnt - l0, L);
    flush_phase();
    enter_run();

    // Warm-up zeros (none when flushing), then an impulse of 64.
    for (int i = 0; i < WarmN; i++) run_cycle(1'b1, '0, 1'b0);
    run_cycle(1'b1, W1'(64), 1'b0);
    for (int i = 0; i < int'(L + LAT); i++) run_cycle(1'b1, '0, 1'b0);

    // Single-cycle underrun, sticky afterwards.
    run_cycle(1'b0, 9'h055, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, W1'(3 * i + 1), 1'b0);

    // Reload mid-RUN with a sample in the same cycle.
    run_cycle(1'b1, W1'(100), 1'b1);
    for (int j = 0; j < 5; j++) begin
      c_valid_i = 1'b1;
      c_data_i  = W1'(j + 20);
      @(negedge clk_i);
      chk("reload_c_ready", c_ready_o, 1);
      chk("reload_underrun", underrun_o, 0);
      chk("reload_busy", busy_o, 1);
      @(posedge clk_i); #1;
    end

    // Asynchronous reset mid-LOAD, then a full signed reload.
    #2 rst_ni = 1'b0;
    #1 chk_reset("mid_load");
    c_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    exp_ur = 1'b0;
    start_load();
    load_coeffs(-7, 1, 1'b0);
    flush_phase();
    enter_run();
    for (int i = 0; i < 40; i++) begin
      run_cycle(($urandom_range(0, 7) != 0), W1'($urandom), 1'b0);
    end
    repeat (LAT + 1) begin
      @(posedge clk_i); #1;
    end
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer for the transposed-form FIR datapath (`fir_gen`). It loads exactly L coefficients through the datapath's shift-in port, then switches the datapath to run mode and feeds it one sample per clock. It tags each sample as real or filler and re-aligns those tags with the filter output, so downstream logic sees a clean valid/data stream. It sits between the sample/coefficient sources and `fir_gen`, and owns `fir_gen`'s `Load_x`, `x_in` and `c_in`.

## Interface
- W1, 9: sample/coefficient width (matches datapath W1)
- W4, 11: output width (matches datapath W4)
- L, 15: filter length; coefficient count per load
- LAT, 2: datapath latency, from `x_in` to `y_out`, in clocks
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- cfg_start  in  1  single-cycle pulse; begin a coefficient reload
- c_valid  in  1  coefficient beat valid
- c_data  in  W1  signed coefficient; first accepted beat ends in tap L-1
- c_ready  out  1  coefficient accept
- s_valid  in  1  sample valid
- s_data  in  W1  signed sample
- s_ready  out  1  sample accept
- fir_load_x  out  1  to datapath `Load_x` (0 = shift coefficient, 1 = take sample)
- fir_x_in  out  W1  to datapath `x_in`
- fir_c_in  out  W1  to datapath `c_in`
- fir_y  in  W4  from datapath `y_out`
- m_valid  out  1  output sample valid
- m_data  out  W4  output sample
- busy  out  1  state is not RUN
- underrun  out  1  sticky flag: RUN cycle with s_valid low

## Operation
- States are IDLE, LOAD, FLUSH (macro-dependent) and RUN. Reset enters IDLE.
- IDLE:
  - fir_load_x=1, fir_x_in=0, c_ready=0, s_ready=0.
  - cfg_start moves to LOAD.
- LOAD:
  - c_ready=1, fir_c_in=c_data (combinational).
  - fir_load_x=0 only in cycles where c_valid=1; otherwise fir_load_x=1 and fir_x_in=0.
  - The beat counter counts 0..L-1.
  - The L-th accepted beat moves to FLUSH, or to RUN when the macro is off.
  - cfg_start is ignored in LOAD.
- FLUSH:
  - Lasts L cycles. fir_load_x=1, fir_x_in=0, s_ready=0.
  - Then moves to RUN.
- RUN:
  - fir_load_x=1, s_ready=1.
  - fir_x_in = s_valid ? s_data : 0. The datapath is clock-rate, so a zero is injected whenever no sample is valid.
  - A tag bit (s_valid) enters an LAT-deep delay line every cycle.
  - cfg_start moves to LOAD and clears the delay line.
- Output path:
  - m_data = fir_y (combinational pass-through).
  - m_valid = tail of the delay line, gated by warm-up logic when the macro is off.
  - There is no back-pressure on m_*; the consumer must accept every cycle.
- underrun:
  - Set in any RUN cycle with s_valid=0 after warm-up.
  - Cleared only by cfg_start or reset.
- Arithmetic: the block performs none. All data pass through at width W1 or W4 unmodified.

## Timing
- Reset values:
  - state=IDLE; fir_load_x=1; fir_x_in=0; fir_c_in=0 (c_ready=0).
  - c_ready=0, s_ready=0, m_valid=0, busy=1, underrun=0.
  - Counters and the delay line are 0.
- Latency: a sample accepted in cycle t appears on m_data with m_valid=1 in cycle t+LAT.
- Load duration: exactly L accepted beats. Gaps (c_valid=0) stretch LOAD but never shift coefficients.
- Handshakes:
  - Coefficient transfer happens on c_valid & c_ready.
  - Sample transfer happens on s_valid & s_ready.
  - Both ready signals are state-derived only; neither depends on the matching valid.
- cfg_start arriving in the same cycle as a RUN sample: the sample is accepted, but its tag is cleared, so it is never marked valid.
- cfg_start during FLUSH: restarts LOAD and resets the flush counter.
- Reset mid-LOAD: the partial coefficient set stays in the datapath. A full reload is required before RUN.
- An output cycle whose tag bit is 0 has m_valid=0 regardless of m_data.

## Configuration
- Macro: FIR_SEQ_FLUSH_EN.
- Defined:
  - FLUSH state is present and injects L zero samples after every load.
  - RUN outputs are valid from the first accepted sample (zero-padded history).
- Undefined:
  - No FLUSH state; LOAD goes directly to RUN.
  - A warm-up counter forces m_valid=0 for the tags of the first L-1 RUN cycles.
  - underrun is not set during warm-up.

## Structure
- Shared package `fir_pkg` holds:
  - the state encoding (IDLE, LOAD, FLUSH, RUN)
  - default constants FIR_L=15, FIR_W1=9, FIR_W4=11, FIR_LAT=2
- One sub-module, `fir_tag_pipe`: a parameterised LAT-deep valid delay line with synchronous clear.

## Test plan
- Reset then idle: reset_n low mid-cycle -> all outputs at reset values immediately; busy=1, m_valid=0 for 20 cycles.
- Load 15 coefficients (c=1..15) with two 3-cycle gaps -> fir_load_x low on exactly 15 cycles; busy stays 1 until the 15th beat (+15 flush cycles with macro).
- Impulse: after loading c=1..15, send sample 64 then zeros -> m_data walks the 15 taps scaled by 64 at datapath output precision; first valid output 2 cycles after the sample is accepted.
- Underrun: drop s_valid for 1 RUN cycle -> fir_x_in=0 that cycle, m_valid=0 exactly 2 cycles later, underrun=1 and stays set.
- Reload mid-RUN: cfg_start while s_valid=1 -> m_valid=0 for in-flight samples, c_ready=1 next cycle, underrun cleared.
- Macro off: after load, 20 consecutive samples -> m_valid=0 for tags of the first 14 RUN cycles, then 1.
